// File: rtl/fwd_hazard_unit.sv
// Forwarding/interlock scoreboard between decode and execute.
// Tracks in-flight destinations by age and produces interlock and forward selects.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 4,
  parameter int LOAD_LAT    = 1,
  parameter int MUL_LAT     = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int FW_SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_stall,
  input  logic                  flush,
  input  logic                  dec_valid,
  input  logic                  dec_rs1_en,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic                  dec_rs2_en,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_rd_en,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic [1:0]            dec_class,
  output logic                  hazard_stall,
  output logic [FW_SEL_W-1:0]   rs1_fw_sel,
  output logic [FW_SEL_W-1:0]   rs2_fw_sel,
  output logic                  ex_bubble
);

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } cls_e;

  logic                  r_valid [DEPTH];
  logic [REG_ADDR_W-1:0] r_rd    [DEPTH];
  logic [FW_SEL_W-1:0]   r_lat   [DEPTH];
  logic [FW_SEL_W-1:0]   r_rs1_sel;
  logic [FW_SEL_W-1:0]   r_rs2_sel;
  logic                  r_bubble;

  logic                  w_rs1_hit, w_rs1_haz;
  logic                  w_rs2_hit, w_rs2_haz;
  logic [FW_SEL_W-1:0]   w_rs1_sel, w_rs2_sel;
  logic [FW_SEL_W-1:0]   w_new_lat;
  logic                  w_new_valid;
  logic                  w_stall;

  always_comb begin
    w_new_lat = '0;
    case (cls_e'(dec_class))
      CLS_LOAD: w_new_lat = FW_SEL_W'(LOAD_LAT);
      CLS_MUL:  w_new_lat = FW_SEL_W'(MUL_LAT);
      default:  w_new_lat = '0;
    endcase
  end

  // Scan young-to-old; the first hit wins, so older aliases are ignored.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs1_haz = 1'b0;
    w_rs1_sel = '0;
    w_rs2_hit = 1'b0;
    w_rs2_haz = 1'b0;
    w_rs2_sel = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!w_rs1_hit && dec_rs1_en && (dec_rs1 != '0) && r_valid[k] && (r_rd[k] == dec_rs1)) begin
        w_rs1_hit = 1'b1;
        if (FW_SEL_W'(k) >= r_lat[k]) w_rs1_sel = FW_SEL_W'(k + 1);
        else                          w_rs1_haz = 1'b1;
      end
      if (!w_rs2_hit && dec_rs2_en && (dec_rs2 != '0) && r_valid[k] && (r_rd[k] == dec_rs2)) begin
        w_rs2_hit = 1'b1;
        if (FW_SEL_W'(k) >= r_lat[k]) w_rs2_sel = FW_SEL_W'(k + 1);
        else                          w_rs2_haz = 1'b1;
      end
    end
  end

  assign w_stall     = dec_valid && (w_rs1_haz || w_rs2_haz) && !flush;
  assign w_new_valid = dec_valid && dec_rd_en && (dec_rd != '0) && !w_stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_rd[k]    <= '0;
        r_lat[k]   <= '0;
      end
      r_rs1_sel <= '0;
      r_rs2_sel <= '0;
      r_bubble  <= 1'b1;
    end else if (!pipe_stall) begin
      // Flush kills the youngest entries as they move, so they never reach a tap.
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1] && !(flush && ((k - 1) < FLUSH_DEPTH));
        r_rd[k]    <= r_rd[k-1];
        r_lat[k]   <= r_lat[k-1];
      end
      r_valid[0] <= w_new_valid;
      r_rd[0]    <= dec_rd;
      r_lat[0]   <= w_new_lat;
      r_rs1_sel  <= (w_stall || flush) ? '0 : w_rs1_sel;
      r_rs2_sel  <= (w_stall || flush) ? '0 : w_rs2_sel;
      r_bubble   <= !dec_valid || w_stall || flush;
    end
  end

  assign hazard_stall = w_stall;
  assign rs1_fw_sel   = r_rs1_sel;
  assign rs2_fw_sel   = r_rs2_sel;
  assign ex_bubble    = r_bubble;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding taps, load/mul interlocks,
// x0 handling, pipe_stall freeze, flush kill and asynchronous reset.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       pipe_stall;
  logic       flush;
  logic       dec_valid;
  logic       dec_rs1_en;
  logic [4:0] dec_rs1;
  logic       dec_rs2_en;
  logic [4:0] dec_rs2;
  logic       dec_rd_en;
  logic [4:0] dec_rd;
  logic [1:0] dec_class;
  logic       hazard_stall;
  logic [2:0] rs1_fw_sel;
  logic [2:0] rs2_fw_sel;
  logic       ex_bubble;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_hazard_unit #(
    .REG_ADDR_W (5),
    .DEPTH      (4),
    .LOAD_LAT   (1),
    .MUL_LAT    (3),
    .FLUSH_DEPTH(2),
    .FW_SEL_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_stall  (pipe_stall),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_rs1_en  (dec_rs1_en),
    .dec_rs1     (dec_rs1),
    .dec_rs2_en  (dec_rs2_en),
    .dec_rs2     (dec_rs2),
    .dec_rd_en   (dec_rd_en),
    .dec_rd      (dec_rd),
    .dec_class   (dec_class),
    .hazard_stall(hazard_stall),
    .rs1_fw_sel  (rs1_fw_sel),
    .rs2_fw_sel  (rs2_fw_sel),
    .ex_bubble   (ex_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic r1e, input logic [4:0] r1,
                     input logic r2e, input logic [4:0] r2,
                     input logic rde, input logic [4:0] rd, input logic [1:0] cls);
    dec_valid  = v;
    dec_rs1_en = r1e;
    dec_rs1    = r1;
    dec_rs2_en = r2e;
    dec_rs2    = r2;
    dec_rd_en  = rde;
    dec_rd     = rd;
    dec_class  = cls;
  endtask

  task automatic idle;
    drv(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic regs(input string tag, input logic [2:0] s1, input logic [2:0] s2, input logic b);
    chk({tag, "_rs1_sel"}, 32'(rs1_fw_sel), 32'(s1));
    chk({tag, "_rs2_sel"}, 32'(rs2_fw_sel), 32'(s2));
    chk({tag, "_bubble"},  32'(ex_bubble),  32'(b));
  endtask

  task automatic haz(input string tag, input logic h);
    #1;
    chk({tag, "_stall"}, 32'(hazard_stall), 32'(h));
  endtask

  initial begin
    rst_n = 1'b0; pipe_stall = 1'b0; flush = 1'b0;
    idle();
    @(negedge clk);
    #1;
    regs("rst", 3'd0, 3'd0, 1'b1);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    rst_n = 1'b1;

    // ALU x5, consumers at distance 1 and 2
    drv(1, 0, 0, 0, 0, 1, 5'd5, 2'd0);          haz("alu_p", 0);
    @(negedge clk);
    drv(1, 1, 5'd5, 1, 5'd5, 1, 5'd6, 2'd0);    haz("alu_c1", 0);
    @(negedge clk);
    regs("alu_c1", 3'd1, 3'd1, 1'b0);
    drv(1, 1, 5'd5, 0, 0, 0, 0, 2'd0);          haz("alu_c2", 0);
    @(negedge clk);
    regs("alu_c2", 3'd2, 3'd0, 1'b0);
    idle();
    @(negedge clk);
    regs("idle", 3'd0, 3'd0, 1'b1);

    // Load-use: one stall cycle, then tap 2
    drv(1, 0, 0, 0, 0, 1, 5'd7, 2'd1);          haz("ld_p", 0);
    @(negedge clk);
    drv(1, 1, 5'd7, 0, 0, 1, 5'd8, 2'd0);       haz("ld_c0", 1);
    @(negedge clk);
    regs("ld_b", 3'd0, 3'd0, 1'b1);             haz("ld_c1", 0);
    @(negedge clk);
    regs("ld_c", 3'd2, 3'd0, 1'b0);

    // Multiply: three stall cycles, then tap 4
    drv(1, 0, 0, 0, 0, 1, 5'd9, 2'd2);          haz("mul_p", 0);
    @(negedge clk);
    drv(1, 0, 0, 1, 5'd9, 1, 5'd11, 2'd0);      haz("mul_c0", 1);
    @(negedge clk);
    regs("mul_b1", 3'd0, 3'd0, 1'b1);           haz("mul_c1", 1);
    @(negedge clk);                             haz("mul_c2", 1);
    @(negedge clk);                             haz("mul_c3", 0);
    @(negedge clk);
    regs("mul_c", 3'd0, 3'd4, 1'b0);

    // Oldest tap, then aged out to the register file
    drv(1, 0, 0, 0, 0, 1, 5'd12, 2'd2);
    @(negedge clk); drv(1, 0, 0, 0, 0, 1, 5'd13, 2'd0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 1, 5'd14, 2'd0);
    @(negedge clk); drv(1, 0, 0, 0, 0, 1, 5'd15, 2'd0);
    @(negedge clk);
    drv(1, 1, 5'd12, 0, 0, 0, 0, 2'd0);         haz("far_k3", 0);
    @(negedge clk);
    regs("far_k3", 3'd4, 3'd0, 1'b0);
    drv(1, 1, 5'd12, 0, 0, 0, 0, 2'd0);         haz("far_k4", 0);
    @(negedge clk);
    regs("far_k4", 3'd0, 3'd0, 1'b0);

    // x0 never allocated, never matched
    drv(1, 0, 0, 0, 0, 1, 5'd0, 2'd1);          haz("x0_p", 0);
    @(negedge clk);
    drv(1, 1, 5'd0, 1, 5'd0, 1, 5'd20, 2'd0);   haz("x0_c", 0);
    @(negedge clk);
    regs("x0_c", 3'd0, 3'd0, 1'b0);

    // Load-use interlock frozen by pipe_stall for 4 edges
    drv(1, 1, 5'd20, 0, 0, 1, 5'd7, 2'd1);      haz("ps_p", 0);
    @(negedge clk);
    regs("ps_p", 3'd1, 3'd0, 1'b0);
    drv(1, 1, 5'd7, 0, 0, 1, 5'd21, 2'd0);
    pipe_stall = 1'b1;                          haz("ps_c0", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      regs("ps_hold", 3'd1, 3'd0, 1'b0);        haz("ps_hold", 1);
    end
    @(negedge clk);
    regs("ps_last", 3'd1, 3'd0, 1'b0);
    pipe_stall = 1'b0;                          haz("ps_resume", 1);
    @(negedge clk);
    regs("ps_b", 3'd0, 3'd0, 1'b1);             haz("ps_c1", 0);
    @(negedge clk);
    regs("ps_c", 3'd2, 3'd0, 1'b0);

    // Flush kills a multiply sitting at k=0
    drv(1, 0, 0, 0, 0, 1, 5'd9, 2'd2);
    @(negedge clk);
    drv(1, 1, 5'd9, 0, 0, 1, 5'd22, 2'd0);
    flush = 1'b1;                               haz("fl_mask", 0);
    @(negedge clk);
    flush = 1'b0;
    regs("fl_b", 3'd0, 3'd0, 1'b1);
    drv(1, 1, 5'd9, 1, 5'd22, 0, 0, 2'd0);      haz("fl_c", 0);
    @(negedge clk);
    regs("fl_c", 3'd0, 3'd0, 1'b0);

    // Async reset during an interlock
    drv(1, 0, 0, 0, 0, 1, 5'd7, 2'd1);
    @(negedge clk);
    drv(1, 1, 5'd7, 0, 0, 0, 0, 2'd0);          haz("ar_pre", 1);
    #1 rst_n = 1'b0;
    haz("ar_post", 0);
    regs("ar", 3'd0, 3'd0, 1'b1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
